tx_packet_fifo: RTL and testbench

//   Parametrised transmit FIFO for 9-bit SpaceWire-style characters (bit 8 = control flag).

---
 rtl/tx_packet_fifo_pkg.sv | 14 +
 rtl/tx_packet_fifo_if.sv | 34 +++
 rtl/tx_packet_fifo_ram_2p.sv | 22 ++
 rtl/tx_packet_fifo.sv | 103 ++++++++++
 tb/tb_tx_packet_fifo.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_packet_fifo_pkg.sv
// Shared character definitions for the transmit packet FIFO.
// A boundary (control) character is any character with its top bit set.
package tx_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_W = 9;

  localparam logic [DEFAULT_DATA_W-1:0] EOP = 9'h100;
  localparam logic [DEFAULT_DATA_W-1:0] EEP = 9'h101;

  function automatic logic isBoundary(input logic [DEFAULT_DATA_W-1:0] c);
    return c[DEFAULT_DATA_W-1];
  endfunction

endpackage

// File: rtl/tx_packet_fifo_if.sv
// Write/read/status bundle between the reply builder, the FIFO and the link transmitter.
interface tx_packet_fifo_if
  import tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 64
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              writeEnable;
  logic [DATA_W-1:0] dataIn;
  logic              full;
  logic              almostFull;
  logic              overflow;
  logic              readEnable;
  logic [DATA_W-1:0] dataOut;
  logic              dataValid;
  logic              empty;
  logic [CNT_W-1:0]  level;
  logic [CNT_W-1:0]  packetCount;
  logic              packetAvail;

  modport master (
    output flush, writeEnable, dataIn, readEnable,
    input  full, almostFull, overflow, dataOut, dataValid, empty, level, packetCount, packetAvail
  );

  modport slave (
    input  flush, writeEnable, dataIn, readEnable,
    output full, almostFull, overflow, dataOut, dataValid, empty, level, packetCount, packetAvail
  );

endinterface

// File: rtl/tx_packet_fifo_ram_2p.sv
// Simple dual-port storage: synchronous write, registered synchronous read, no reset.
module fifo_ram_2p #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_packet_fifo.sv
// Transmit character FIFO with fill level, almost-full, sticky overflow, flush
// and a count of packet-boundary characters currently held.
module tx_packet_fifo
  import tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
  input  logic           clk,
  input  logic           rst,
  tx_packet_fifo_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  level_q, level_n;
  logic [CNT_W-1:0]  pkt_q, pkt_n;
  logic              full_q, empty_q, afull_q, ovf_q, valid_q, avail_q;
  logic              seen_q;
  logic [DEPTH-1:0]  ctrl_bits;
  logic [DATA_W-1:0] ram_q;
  logic              wr_acc, rd_acc, wr_bnd, rd_bnd;

  // Acceptance and next-state level/boundary count; flush overrides everything.
  always_comb begin
    wr_acc  = bus.writeEnable && !full_q && !bus.flush;
    rd_acc  = bus.readEnable && !empty_q && !bus.flush;
    wr_bnd  = wr_acc && isBoundary(bus.dataIn);
    rd_bnd  = rd_acc && ctrl_bits[rd_ptr];
    level_n = level_q;
    pkt_n   = pkt_q;
    if (bus.flush) begin
      level_n = '0;
      pkt_n   = '0;
    end else begin
      if (wr_acc && !rd_acc)      level_n = level_q + CNT_W'(1);
      else if (rd_acc && !wr_acc) level_n = level_q - CNT_W'(1);
      if (wr_bnd && !rd_bnd)      pkt_n = pkt_q + CNT_W'(1);
      else if (rd_bnd && !wr_bnd) pkt_n = pkt_q - CNT_W'(1);
    end
  end

  // Control-flag shadow so the boundary count can drop on the read edge itself.
  always_ff @(posedge clk) begin
    if (wr_acc) ctrl_bits[wr_ptr] <= bus.dataIn[DATA_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      pkt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
      avail_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      wr_ptr  <= bus.flush ? '0 : (wr_acc ? wr_ptr + ADDR_W'(1) : wr_ptr);
      rd_ptr  <= bus.flush ? '0 : (rd_acc ? rd_ptr + ADDR_W'(1) : rd_ptr);
      level_q <= level_n;
      pkt_q   <= pkt_n;
      full_q  <= (level_n == CNT_W'(DEPTH));
      empty_q <= (level_n == '0);
      afull_q <= (level_n >= CNT_W'(AFULL_THRESH));
      avail_q <= (pkt_n != '0);
      ovf_q   <= !bus.flush && (ovf_q || (bus.writeEnable && full_q));
      valid_q <= rd_acc;
      seen_q  <= seen_q || rd_acc;
    end
  end

  fifo_ram_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.dataIn),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // The RAM output register has no reset; mask it until the first read after reset.
  assign bus.dataOut     = seen_q ? ram_q : '0;
  assign bus.dataValid   = valid_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almostFull  = afull_q;
  assign bus.overflow    = ovf_q;
  assign bus.level       = level_q;
  assign bus.packetCount = pkt_q;
  assign bus.packetAvail = avail_q;

endmodule

// File: tb/tb_tx_packet_fifo.sv
// Directed bench for tx_packet_fifo: a DEPTH=64 instance for the main sequence
// and a DEPTH=8 instance for pointer wrap-around.
module tb_tx_packet_fifo;
  import tx_fifo_pkg::*;

  logic clk, rst, clk_en;
  int   n_assert, n_fail;

  tx_packet_fifo_if #(.DATA_W(9), .DEPTH(64)) ifa ();
  tx_packet_fifo_if #(.DATA_W(9), .DEPTH(8))  ifb ();

  tx_packet_fifo #(.DATA_W(9), .DEPTH(64), .AFULL_THRESH(60)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  tx_packet_fifo #(.DATA_W(9), .DEPTH(8), .AFULL_THRESH(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] q[$];
  logic [8:0] exp_v;
  bit         wa, ra;
  int         nb;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    ifa.flush = 1'b0; ifa.writeEnable = 1'b0; ifa.readEnable = 1'b0; ifa.dataIn = '0;
    ifb.flush = 1'b0; ifb.writeEnable = 1'b0; ifb.readEnable = 1'b0; ifb.dataIn = '0;

    // 1. reset with no clock running
    #2 rst = 1'b1;
    #2;
    chk("rst_empty", 32'(ifa.empty), 1);
    chk("rst_full", 32'(ifa.full), 0);
    chk("rst_level", 32'(ifa.level), 0);
    chk("rst_valid", 32'(ifa.dataValid), 0);
    chk("rst_pkt", 32'(ifa.packetCount), 0);
    chk("rst_avail", 32'(ifa.packetAvail), 0);
    chk("rst_ovf", 32'(ifa.overflow), 0);
    chk("rst_afull", 32'(ifa.almostFull), 0);
    chk("rst_dout", 32'(ifa.dataOut), 0);
    chk("rst_small_empty", 32'(ifb.empty), 1);
    #2 rst = 1'b0;
    clk_en = 1'b1;
    tick();

    // 2. fill to full, overflow, drain in order
    for (int i = 0; i < 64; i++) begin
      ifa.writeEnable = 1'b1;
      ifa.dataIn = 9'(i);
      tick();
      chk("t2_level", 32'(ifa.level), i + 1);
      chk("t2_afull", 32'(ifa.almostFull), (i + 1 >= 60) ? 1 : 0);
      chk("t2_full", 32'(ifa.full), (i + 1 == 64) ? 1 : 0);
    end
    ifa.dataIn = 9'h040;
    tick();
    chk("t2_ovf", 32'(ifa.overflow), 1);
    chk("t2_level_hold", 32'(ifa.level), 64);
    ifa.writeEnable = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ifa.readEnable = 1'b1;
      tick();
      chk("t2_dout", 32'(ifa.dataOut), i);
      chk("t2_valid", 32'(ifa.dataValid), 1);
    end
    ifa.readEnable = 1'b0;
    tick();
    chk("t2_valid_idle", 32'(ifa.dataValid), 0);
    chk("t2_empty", 32'(ifa.empty), 1);
    chk("t2_ovf_sticky", 32'(ifa.overflow), 1);

    // 3. packet boundary counting
    ifa.writeEnable = 1'b1;
    ifa.dataIn = 9'h0AA; tick();
    ifa.dataIn = 9'h0BB; tick();
    ifa.dataIn = EOP;    tick();
    ifa.dataIn = 9'h0CC; tick();
    ifa.dataIn = EEP;    tick();
    ifa.writeEnable = 1'b0;
    chk("t3_pkt", 32'(ifa.packetCount), 2);
    chk("t3_avail", 32'(ifa.packetAvail), 1);
    chk("t3_level", 32'(ifa.level), 5);
    ifa.readEnable = 1'b1;
    tick(); chk("t3_rd0", 32'(ifa.dataOut), 'h0AA);
    tick(); chk("t3_rd1", 32'(ifa.dataOut), 'h0BB);
    chk("t3_pkt_mid", 32'(ifa.packetCount), 2);
    tick(); chk("t3_rd2", 32'(ifa.dataOut), 'h100);
    chk("t3_pkt_after", 32'(ifa.packetCount), 1);
    chk("t3_avail_after", 32'(ifa.packetAvail), 1);
    tick(); chk("t3_rd3", 32'(ifa.dataOut), 'h0CC);
    tick(); chk("t3_rd4", 32'(ifa.dataOut), 'h101);
    ifa.readEnable = 1'b0;
    chk("t3_pkt_zero", 32'(ifa.packetCount), 0);
    chk("t3_avail_zero", 32'(ifa.packetAvail), 0);

    // 4. simultaneous read+write at level 10, then at full
    for (int i = 0; i < 10; i++) begin
      ifa.writeEnable = 1'b1;
      ifa.dataIn = 9'(16 + i);
      tick();
    end
    chk("t4_level10", 32'(ifa.level), 10);
    for (int k = 0; k < 5; k++) begin
      ifa.writeEnable = 1'b1;
      ifa.readEnable = 1'b1;
      ifa.dataIn = 9'(80 + k);
      tick();
      chk("t4_rw_level", 32'(ifa.level), 10);
      chk("t4_rw_dout", 32'(ifa.dataOut), 16 + k);
    end
    ifa.readEnable = 1'b0;
    for (int j = 0; j < 54; j++) begin
      ifa.writeEnable = 1'b1;
      ifa.dataIn = 9'(384 + j);
      tick();
    end
    ifa.writeEnable = 1'b0;
    chk("t4_full", 32'(ifa.full), 1);
    chk("t4_pkt54", 32'(ifa.packetCount), 54);
    // Only the first cycle sees full; later writes land in the slot just freed.
    for (int k = 0; k < 5; k++) begin
      ifa.writeEnable = 1'b1;
      ifa.readEnable = 1'b1;
      ifa.dataIn = 9'(96 + k);
      tick();
      chk("t4_full_dout", 32'(ifa.dataOut), 21 + k);
      chk("t4_full_level", 32'(ifa.level), 63);
      chk("t4_full_ovf", 32'(ifa.overflow), 1);
    end
    chk("t4_full_drop", 32'(ifa.full), 0);
    ifa.writeEnable = 1'b0;
    ifa.readEnable = 1'b0;

    // 5. drain to level 20, then flush with a concurrent write
    for (int i = 0; i < 43; i++) begin
      ifa.readEnable = 1'b1;
      tick();
    end
    ifa.readEnable = 1'b0;
    chk("t5_last_rd", 32'(ifa.dataOut), 'h1A5);
    chk("t5_level20", 32'(ifa.level), 20);
    chk("t5_pkt16", 32'(ifa.packetCount), 16);
    chk("t5_ovf_pre", 32'(ifa.overflow), 1);
    ifa.flush = 1'b1;
    ifa.writeEnable = 1'b1;
    ifa.dataIn = 9'h1FF;
    tick();
    ifa.flush = 1'b0;
    ifa.writeEnable = 1'b0;
    chk("t5_level", 32'(ifa.level), 0);
    chk("t5_empty", 32'(ifa.empty), 1);
    chk("t5_ovf", 32'(ifa.overflow), 0);
    chk("t5_pkt", 32'(ifa.packetCount), 0);
    chk("t5_avail", 32'(ifa.packetAvail), 0);
    chk("t5_full", 32'(ifa.full), 0);
    chk("t5_valid", 32'(ifa.dataValid), 0);
    chk("t5_dout_hold", 32'(ifa.dataOut), 'h1A5);
    // empty with read+write: write taken, read ignored
    ifa.writeEnable = 1'b1;
    ifa.readEnable = 1'b1;
    ifa.dataIn = 9'h033;
    tick();
    chk("t5_er_valid", 32'(ifa.dataValid), 0);
    chk("t5_er_level", 32'(ifa.level), 1);
    ifa.writeEnable = 1'b0;
    tick();
    chk("t5_er_dout", 32'(ifa.dataOut), 'h033);
    chk("t5_er_valid2", 32'(ifa.dataValid), 1);
    chk("t5_er_empty", 32'(ifa.empty), 1);
    ifa.readEnable = 1'b0;
    tick();

    // 6. reset asserted between a read request and the next edge
    for (int k = 1; k <= 3; k++) begin
      ifa.writeEnable = 1'b1;
      ifa.dataIn = 9'(k);
      tick();
    end
    ifa.writeEnable = 1'b0;
    ifa.readEnable = 1'b1;
    tick();
    chk("t6_pre_valid", 32'(ifa.dataValid), 1);
    chk("t6_pre_dout", 32'(ifa.dataOut), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(ifa.dataValid), 0);
    chk("t6_rst_level", 32'(ifa.level), 0);
    chk("t6_rst_empty", 32'(ifa.empty), 1);
    chk("t6_rst_dout", 32'(ifa.dataOut), 0);
    tick();
    rst = 1'b0;
    ifa.readEnable = 1'b0;
    ifa.writeEnable = 1'b1;
    ifa.dataIn = 9'h077;
    tick();
    chk("t6_first_wr", 32'(ifa.level), 1);
    ifa.writeEnable = 1'b0;
    ifa.readEnable = 1'b1;
    tick();
    chk("t6_first_rd", 32'(ifa.dataOut), 'h077);
    ifa.readEnable = 1'b0;

    // wrap-around at DEPTH=8 against a queue model
    for (int i = 0; i < 200; i++) begin
      ifb.writeEnable = (i % 5 != 4);
      ifb.readEnable  = (i % 3 != 2);
      ifb.dataIn      = 9'(i * 3 + 1);
      wa = ifb.writeEnable && (q.size() < 8);
      ra = ifb.readEnable && (q.size() > 0);
      if (ra) exp_v = q.pop_front();
      if (wa) q.push_back(ifb.dataIn);
      tick();
      chk("wrap_valid", 32'(ifb.dataValid), ra ? 1 : 0);
      if (ra) chk("wrap_data", 32'(ifb.dataOut), 32'(exp_v));
      chk("wrap_level", 32'(ifb.level), q.size());
      nb = 0;
      foreach (q[k]) nb += int'(q[k][8]);
      chk("wrap_pkt", 32'(ifb.packetCount), nb);
    end
    ifb.writeEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifb.readEnable = 1'b1;
      ra = (q.size() > 0);
      if (ra) exp_v = q.pop_front();
      tick();
      chk("drain_valid", 32'(ifb.dataValid), ra ? 1 : 0);
      if (ra) chk("drain_data", 32'(ifb.dataOut), 32'(exp_v));
    end
    ifb.readEnable = 1'b0;
    chk("drain_empty", 32'(ifb.empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
